vexriscv_ibus_axi_reader: RTL and testbench
===========================================

// Module: vexriscv_ibus_axi_reader
// PURPOSE
//  Converts the VexRiscv instruction-cache refill bus (iBus cmd/rsp) into AXI4 read bursts on the
//  m01_axi port of the kernel. It sits between the VexRiscv core and the kernel's m01_axi master:
//  - accepts one refill command at a time;
//  - translates the address into host-buffer space;
//  - issues a single INCR burst and streams the beats back to the core.
//  Replaces the combinational iBus glue.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  64  AXI address width (>=32)
//  C_M_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported
// PORTS
//  ap_clk                    in   1      kernel clock
//  ap_rst_n                  in   1      async active-low reset
//  iBus_cmd_valid            in   1      refill request
//  iBus_cmd_ready            out  1      request accepted this cycle
//  iBus_cmd_payload_address  in   32     byte address from core
//  iBus_cmd_payload_size     in   3      log2(bytes) of refill
//  iBus_rsp_valid            out  1      one 32-bit beat to core (no backpressure)
//  iBus_rsp_payload_data     out  32     beat data
//  iBus_rsp_payload_error    out  1      beat carried SLVERR/DECERR
//  abs_address               in   32     addresses > this are absolute (untranslated)
//  base_offset               in   64     host buffer base added to addresses <= abs_address
//  m_axi_arvalid / arready   out/in 1    AR handshake
//  m_axi_araddr              out  ADDR_W translated, aligned burst address
//  m_axi_arlen               out  8      beats-1
//  m_axi_arsize              out  3      constant 3'b010
//  m_axi_arburst             out  2      constant 2'b01 (INCR)
//  m_axi_rvalid / rready     in/out 1    R handshake
//  m_axi_rdata               in   32     read data
//  m_axi_rresp               in   2      read response
//  m_axi_rlast               in   1      last beat
//  protocol_err              out  1      sticky: beat count and rlast disagreed
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE. All outputs 0, except cmd_ready=1.
//  - FSM IDLE -> AR -> DATA -> IDLE.
//  - IDLE: cmd_ready=1.
//    - On cmd_valid, latch the following and go to AR:
//      - the aligned address;
//      - beats = (size<=2) ? 1 : 2^(size-2), range 1..32;
//      - the translated base.
//  - Alignment: low max(size,2) address bits are forced to 0.
//  - Translation, evaluated once at accept with abs_address/base_offset sampled then:
//    - addr > abs_address (unsigned, strict): araddr = zero-extended addr;
//    - otherwise: araddr = addr + base_offset, a full ADDR_W-bit sum with carry discarded.
//  - AR: arvalid=1; araddr/arlen stable until arready. arlen = beats-1.
//    On arvalid&&arready, clear beat_cnt and go to DATA. cmd_ready=0 in AR and DATA.
//  - DATA: rready=1 in every DATA cycle; rready=0 in every other state.
//    - Each R handshake registers one core beat, so iBus_rsp_valid pulses exactly 1 cycle after the R beat:
//      - rsp_data=rdata;
//      - rsp_error=rresp[1].
//    - beat_cnt increments on each handshake.
//  - End of burst, on the handshake where rlast=1 OR beat_cnt==beats-1:
//    - go to IDLE;
//    - if the two conditions differ, set protocol_err.
//    Beats are not dropped or padded. protocol_err clears only on reset.
//  - Latency: cmd accept -> arvalid next cycle. First rsp_valid = 1 cycle after first R beat.
//  - Back-to-back: a new cmd can be accepted the cycle after the final R beat, in IDLE.
//    At most one burst is outstanding; there is no AR/R overlap.
//  - rvalid outside DATA is ignored (rready=0). Changes on cmd inputs while not in IDLE are ignored.
//  - Reset mid-burst: FSM is forced to IDLE and rsp_valid is cleared.
//    The AXI side must be reset by the same ap_rst_n.
// TESTING
//  1. Translated refill: abs=0x8000_0000, base=0x1_0000_0000, cmd addr 0x0000_1234 size 5
//     -> araddr=0x1_0000_1220, arlen=7; 8 rsp beats in order; back to IDLE.
//  2. Absolute: abs=0x8000_0000, addr 0x9000_0040 size 5 -> araddr=0x9000_0040, no offset.
//     Also addr==abs exactly -> offset added (strict compare).
//  3. Single word: size 2 at addr 0x10 -> arlen=0. One beat with rlast=1 -> rsp_valid 1 cycle later.
//     protocol_err stays 0.
//  4. Stalls: arready low 5 cycles, then random rvalid gaps; rresp=2'b10 on beat 3 of 8
//     -> araddr stable while arvalid=1; rsp_error=1 only on beat 3; cmd_ready stays 0 until done.
//  5. Early rlast on beat 4 of 8 -> FSM returns to IDLE after beat 4, protocol_err=1 and sticky.
//     Next cmd is accepted normally.
//  6. Assert ap_rst_n low during beat 2 of 8 -> all outputs 0 asynchronously; cmd_ready=1 after release.
//     A new refill completes correctly.

Source files
------------

// File: rtl/vexriscv_ibus_axi_reader_if.sv
// Refill-side (VexRiscv iBus) and AXI4 read-channel signals of the iBus reader.
// master = the reader itself, slave = core plus AXI fabric on the other side.
interface vexriscv_ibus_axi_reader_if #(
  parameter int ADDR_W = 64
);
  logic              iBus_cmd_valid;
  logic              iBus_cmd_ready;
  logic [31:0]       iBus_cmd_payload_address;
  logic [2:0]        iBus_cmd_payload_size;
  logic              iBus_rsp_valid;
  logic [31:0]       iBus_rsp_payload_data;
  logic              iBus_rsp_payload_error;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;

  modport master (
    input  iBus_cmd_valid, iBus_cmd_payload_address, iBus_cmd_payload_size,
    output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_data, iBus_rsp_payload_error,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
  );

  modport slave (
    output iBus_cmd_valid, iBus_cmd_payload_address, iBus_cmd_payload_size,
    input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_data, iBus_rsp_payload_error,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
  );
endinterface

// File: rtl/vexriscv_ibus_axi_reader.sv
// iBus refill -> one AXI4 INCR read burst; arvalid 1 cycle after cmd accept, rsp 1 cycle after each R beat.
// One burst in flight: cmd_ready low until the last beat; rsp has no backpressure, so rready=1 throughout DATA.
module vexriscv_ibus_axi_reader #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst_n,
  vexriscv_ibus_axi_reader_if.master         bus,
  input  logic [31:0]                        abs_address,
  input  logic [63:0]                        base_offset,
  output logic                               protocol_err
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA} state_t;

  state_t                        state_q;
  logic                          cmd_ready_q;
  logic                          arvalid_q;
  logic [AW-1:0]                 araddr_q;
  logic [4:0]                    beats_m1_q;
  logic                          rready_q;
  logic [4:0]                    beat_cnt_q;
  logic                          rsp_valid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic                          rsp_error_q;
  logic                          protocol_err_q;

  logic [2:0]    align_sh;
  logic [31:0]   aligned_addr;
  logic [5:0]    beats;
  logic [4:0]    beats_m1_d;
  logic [AW-1:0] araddr_d;
  logic          cnt_done;
  logic          unused_rresp0;

  // Refills are at least one word, so the low two address bits always go.
  always_comb begin
    align_sh     = (bus.iBus_cmd_payload_size < 3'd2) ? 3'd2 : bus.iBus_cmd_payload_size;
    aligned_addr = bus.iBus_cmd_payload_address & (32'hFFFF_FFFF << align_sh);
    beats        = 6'd1;
    beats_m1_d   = 5'd0;
    if (bus.iBus_cmd_payload_size > 3'd2) begin
      beats      = 6'd1 << (bus.iBus_cmd_payload_size - 3'd2);
      beats_m1_d = 5'(beats - 6'd1);
    end
    if (aligned_addr > abs_address)
      araddr_d = AW'(aligned_addr);
    else
      araddr_d = AW'(aligned_addr) + base_offset[AW-1:0];
  end

  assign cnt_done      = (beat_cnt_q == beats_m1_q);
  assign unused_rresp0 = bus.m_axi_rresp[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b1;
      arvalid_q      <= 1'b0;
      araddr_q       <= '0;
      beats_m1_q     <= '0;
      rready_q       <= 1'b0;
      beat_cnt_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_error_q    <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iBus_cmd_valid) begin
            araddr_q    <= araddr_d;
            beats_m1_q  <= beats_m1_d;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b1;
            state_q     <= S_AR;
          end
        end
        S_AR: begin
          if (bus.m_axi_arready) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          // rready_q is held high in DATA, so rvalid alone marks a handshake.
          if (bus.m_axi_rvalid) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.m_axi_rdata;
            rsp_error_q <= bus.m_axi_rresp[1];
            beat_cnt_q  <= beat_cnt_q + 5'd1;
            if (bus.m_axi_rlast || cnt_done) begin
              rready_q    <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
              if (bus.m_axi_rlast != cnt_done)
                protocol_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iBus_cmd_ready         = cmd_ready_q;
  assign bus.iBus_rsp_valid         = rsp_valid_q;
  assign bus.iBus_rsp_payload_data  = rsp_data_q;
  assign bus.iBus_rsp_payload_error = rsp_error_q;
  assign bus.m_axi_arvalid          = arvalid_q;
  assign bus.m_axi_araddr           = araddr_q;
  assign bus.m_axi_arlen            = {3'b000, beats_m1_q};
  assign bus.m_axi_arsize           = 3'b010;
  assign bus.m_axi_arburst          = 2'b01;
  assign bus.m_axi_rready           = rready_q;
  assign protocol_err               = protocol_err_q;
endmodule

// File: tb/tb_vexriscv_ibus_axi_reader.sv
// Directed bench for vexriscv_ibus_axi_reader: translation, stalls, rlast errors, reset mid-burst.
module tb_vexriscv_ibus_axi_reader;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] abs_address;
  logic [63:0] base_offset;
  logic        protocol_err;
  int pass_cnt = 0;
  int check_cnt = 0;

  vexriscv_ibus_axi_reader_if #(.ADDR_W(64)) bus ();

  vexriscv_ibus_axi_reader #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus),
    .abs_address(abs_address), .base_offset(base_offset), .protocol_err(protocol_err)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: all called and returning at a negedge.
  task automatic send_cmd(input logic [31:0] a, input logic [2:0] s);
    bus.iBus_cmd_valid = 1'b1; bus.iBus_cmd_payload_address = a; bus.iBus_cmd_payload_size = s;
    @(negedge ap_clk);
    bus.iBus_cmd_valid = 1'b0;
  endtask

  task automatic ar_hs();
    bus.m_axi_arready = 1'b1;
    @(negedge ap_clk);
    bus.m_axi_arready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] r, input logic l, input int gap,
                        output logic v, output logic [31:0] od, output logic oe);
    repeat (gap) @(negedge ap_clk);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = d; bus.m_axi_rresp = r; bus.m_axi_rlast = l;
    @(negedge ap_clk);
    v = bus.iBus_rsp_valid; od = bus.iBus_rsp_payload_data; oe = bus.iBus_rsp_payload_error;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
  endtask

  task automatic test_reset();
    bus.iBus_cmd_valid = 0; bus.iBus_cmd_payload_address = 0; bus.iBus_cmd_payload_size = 0;
    bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0; bus.m_axi_rlast = 0;
    abs_address = 32'h8000_0000; base_offset = 64'h1_0000_0000;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_cnt++; if (bus.iBus_cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", bus.iBus_cmd_ready); else pass_cnt++;
    check_cnt++; if ({bus.m_axi_arvalid, bus.m_axi_rready, bus.iBus_rsp_valid, protocol_err} !== 4'b0000)
      $display("FAIL rst_ctrl got %b exp 0000", {bus.m_axi_arvalid, bus.m_axi_rready, bus.iBus_rsp_valid, protocol_err}); else pass_cnt++;
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== 72'h0) $display("FAIL rst_ar got %h/%h exp 0/0", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
  endtask

  task automatic test_translated();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_1234, 3'd5);
    check_cnt++; if ({bus.m_axi_arvalid, bus.iBus_cmd_ready} !== 2'b10) $display("FAIL t1_arvalid got %b exp 10", {bus.m_axi_arvalid, bus.iBus_cmd_ready}); else pass_cnt++;
    check_cnt++; if (bus.m_axi_araddr !== 64'h0000_0001_0000_1220) $display("FAIL t1_araddr got %h exp 0000000100001220", bus.m_axi_araddr); else pass_cnt++;
    check_cnt++; if (bus.m_axi_arlen !== 8'd7) $display("FAIL t1_arlen got %0d exp 7", bus.m_axi_arlen); else pass_cnt++;
    check_cnt++; if ({bus.m_axi_arsize, bus.m_axi_arburst} !== 5'b010_01) $display("FAIL t1_size_burst got %b exp 01001", {bus.m_axi_arsize, bus.m_axi_arburst}); else pass_cnt++;
    ar_hs();
    check_cnt++; if ({bus.m_axi_arvalid, bus.m_axi_rready} !== 2'b01) $display("FAIL t1_data_phase got %b exp 01", {bus.m_axi_arvalid, bus.m_axi_rready}); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      r_beat(32'hA000_0000 + i, 2'b00, i == 7, 0, v, d, e);
      check_cnt++; if ({v, d, e} !== {1'b1, 32'hA000_0000 + i, 1'b0}) $display("FAIL t1_beat%0d got v%b %h e%b exp v1 %h e0", i, v, d, e, 32'hA000_0000 + i); else pass_cnt++;
    end
    check_cnt++; if ({bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err} !== 3'b100) $display("FAIL t1_end got %b exp 100", {bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err}); else pass_cnt++;
  endtask

  task automatic test_absolute();
    logic v, e; logic [31:0] d;
    send_cmd(32'h9000_0040, 3'd5);
    check_cnt++; if (bus.m_axi_araddr !== 64'h0000_0000_9000_0040) $display("FAIL t2_abs_araddr got %h exp 0000000090000040", bus.m_axi_araddr); else pass_cnt++;
    ar_hs();
    for (int i = 0; i < 8; i++) begin
      r_beat(32'h0B00_0000 + i, 2'b00, i == 7, 0, v, d, e);
      check_cnt++; if ({v, d} !== {1'b1, 32'h0B00_0000 + i}) $display("FAIL t2_beat%0d got v%b %h exp v1 %h", i, v, d, 32'h0B00_0000 + i); else pass_cnt++;
    end
    send_cmd(32'h8000_0000, 3'd2);
    check_cnt++; if (bus.m_axi_araddr !== 64'h0000_0001_8000_0000) $display("FAIL t2_eq_araddr got %h exp 0000000180000000", bus.m_axi_araddr); else pass_cnt++;
    ar_hs();
    r_beat(32'h1, 2'b00, 1'b1, 0, v, d, e);
    send_cmd(32'h8000_0004, 3'd2);
    check_cnt++; if (bus.m_axi_araddr !== 64'h0000_0000_8000_0004) $display("FAIL t2_gt_araddr got %h exp 0000000080000004", bus.m_axi_araddr); else pass_cnt++;
    ar_hs();
    r_beat(32'h2, 2'b00, 1'b1, 0, v, d, e);
  endtask

  task automatic test_single();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_0010, 3'd2);
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== {64'h0000_0001_0000_0010, 8'd0}) $display("FAIL t3_ar got %h/%0d exp 0000000100000010/0", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    r_beat(32'hDEAD_BEEF, 2'b00, 1'b1, 0, v, d, e);
    check_cnt++; if ({v, d, e} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) $display("FAIL t3_beat got v%b %h e%b exp v1 deadbeef e0", v, d, e); else pass_cnt++;
    check_cnt++; if (bus.iBus_cmd_ready !== 1'b1) $display("FAIL t3_idle got %b exp 1", bus.iBus_cmd_ready); else pass_cnt++;
    @(negedge ap_clk);
    check_cnt++; if ({bus.iBus_rsp_valid, protocol_err} !== 2'b00) $display("FAIL t3_pulse got %b exp 00", {bus.iBus_rsp_valid, protocol_err}); else pass_cnt++;
  endtask

  task automatic test_stalls();
    logic v, e; logic [31:0] d; logic [1:0] r;
    int gaps[8] = '{1, 0, 3, 2, 0, 1, 0, 2};
    send_cmd(32'h0000_2000, 3'd5);
    bus.iBus_cmd_valid = 1'b1; bus.iBus_cmd_payload_address = 32'hFFFF_FF00; bus.iBus_cmd_payload_size = 3'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      check_cnt++; if ({bus.m_axi_arvalid, bus.iBus_cmd_ready, bus.m_axi_araddr} !== {2'b10, 64'h0000_0001_0000_2000})
        $display("FAIL t4_stall%0d got v%b r%b %h exp v1 r0 0000000100002000", c, bus.m_axi_arvalid, bus.iBus_cmd_ready, bus.m_axi_araddr); else pass_cnt++;
    end
    bus.iBus_cmd_valid = 1'b0;
    ar_hs();
    check_cnt++; if (bus.m_axi_arlen !== 8'd7) $display("FAIL t4_arlen got %0d exp 7", bus.m_axi_arlen); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      r = (i == 2) ? 2'b10 : ((i == 5) ? 2'b01 : 2'b00);
      r_beat(32'hC000_0000 + i, r, i == 7, gaps[i], v, d, e);
      check_cnt++; if ({v, d, e} !== {1'b1, 32'hC000_0000 + i, i == 2})
        $display("FAIL t4_beat%0d got v%b %h e%b exp v1 %h e%b", i, v, d, e, 32'hC000_0000 + i, i == 2); else pass_cnt++;
      check_cnt++; if (bus.iBus_cmd_ready !== (i == 7)) $display("FAIL t4_cmd_ready%0d got %b exp %b", i, bus.iBus_cmd_ready, i == 7); else pass_cnt++;
    end
  endtask

  task automatic test_early_rlast();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_3000, 3'd5);
    ar_hs();
    for (int i = 0; i < 4; i++) begin
      r_beat(32'hE000_0000 + i, 2'b00, i == 3, 0, v, d, e);
      check_cnt++; if ({v, d} !== {1'b1, 32'hE000_0000 + i}) $display("FAIL t5_beat%0d got v%b %h exp v1 %h", i, v, d, 32'hE000_0000 + i); else pass_cnt++;
    end
    check_cnt++; if ({bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err} !== 3'b101) $display("FAIL t5_early got %b exp 101", {bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err}); else pass_cnt++;
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h5555_5555;
    @(negedge ap_clk);
    bus.m_axi_rvalid = 1'b0;
    check_cnt++; if ({bus.iBus_rsp_valid, bus.iBus_cmd_ready} !== 2'b01) $display("FAIL t5_stray_r got %b exp 01", {bus.iBus_rsp_valid, bus.iBus_cmd_ready}); else pass_cnt++;
    send_cmd(32'h0000_0100, 3'd3);
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== {64'h0000_0001_0000_0100, 8'd1}) $display("FAIL t5_next_ar got %h/%0d exp 0000000100000100/1", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    r_beat(32'h0F00_0000, 2'b00, 1'b0, 0, v, d, e);
    r_beat(32'h0F00_0001, 2'b00, 1'b1, 0, v, d, e);
    check_cnt++; if ({v, d, protocol_err, bus.iBus_cmd_ready} !== {1'b1, 32'h0F00_0001, 2'b11}) $display("FAIL t5_next_end got v%b %h pe%b r%b exp v1 0f000001 pe1 r1", v, d, protocol_err, bus.iBus_cmd_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_0400, 3'd3);
    ar_hs();
    r_beat(32'h7000_0000, 2'b00, 1'b0, 0, v, d, e);
    r_beat(32'h7000_0001, 2'b00, 1'b1, 0, v, d, e);
    send_cmd(32'h0000_0500, 3'd2);
    check_cnt++; if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen} !== {1'b1, 64'h0000_0001_0000_0500, 8'd0})
      $display("FAIL b2b_ar got v%b %h/%0d exp v1 0000000100000500/0", bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    r_beat(32'h7000_0002, 2'b00, 1'b1, 0, v, d, e);
    check_cnt++; if ({v, d} !== {1'b1, 32'h7000_0002}) $display("FAIL b2b_beat got v%b %h exp v1 70000002", v, d); else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_03FC, 3'd7);
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== {64'h0000_0001_0000_0380, 8'd31}) $display("FAIL bnd_size7 got %h/%0d exp 0000000100000380/31", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    for (int i = 0; i < 32; i++) begin
      r_beat(32'h3300_0000 + i, 2'b00, i == 31, 0, v, d, e);
      check_cnt++; if ({v, d} !== {1'b1, 32'h3300_0000 + i}) $display("FAIL bnd_beat%0d got v%b %h exp v1 %h", i, v, d, 32'h3300_0000 + i); else pass_cnt++;
    end
    check_cnt++; if (bus.iBus_cmd_ready !== 1'b1) $display("FAIL bnd_size7_end got %b exp 1", bus.iBus_cmd_ready); else pass_cnt++;
    send_cmd(32'h0000_0013, 3'd0);
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== {64'h0000_0001_0000_0010, 8'd0}) $display("FAIL bnd_size0 got %h/%0d exp 0000000100000010/0", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    r_beat(32'h1, 2'b00, 1'b1, 0, v, d, e);
    base_offset = 64'hFFFF_FFFF_FFFF_FFF0;
    send_cmd(32'h0000_0020, 3'd2);
    check_cnt++; if (bus.m_axi_araddr !== 64'h0000_0000_0000_0010) $display("FAIL bnd_carry got %h exp 0000000000000010", bus.m_axi_araddr); else pass_cnt++;
    ar_hs();
    r_beat(32'h2, 2'b00, 1'b1, 0, v, d, e);
    base_offset = 64'h1_0000_0000;
  endtask

  task automatic test_reset_mid_burst();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_1234, 3'd5);
    ar_hs();
    r_beat(32'h1111_1111, 2'b10, 1'b0, 0, v, d, e);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h2222_2222;
    #2 ap_rst_n = 1'b0;
    #1;
    check_cnt++; if ({bus.iBus_rsp_valid, bus.iBus_rsp_payload_data, bus.iBus_rsp_payload_error} !== 34'h0)
      $display("FAIL rstmid_rsp got v%b %h e%b exp all 0", bus.iBus_rsp_valid, bus.iBus_rsp_payload_data, bus.iBus_rsp_payload_error); else pass_cnt++;
    check_cnt++; if ({bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_araddr, bus.m_axi_arlen} !== 74'h0)
      $display("FAIL rstmid_axi got v%b r%b %h/%0d exp all 0", bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    check_cnt++; if (protocol_err !== 1'b0) $display("FAIL rstmid_perr got %b exp 0", protocol_err); else pass_cnt++;
    bus.m_axi_rvalid = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_cnt++; if (bus.iBus_cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready got %b exp 1", bus.iBus_cmd_ready); else pass_cnt++;
    send_cmd(32'h0000_0044, 3'd4);
    check_cnt++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== {64'h0000_0001_0000_0040, 8'd3}) $display("FAIL rstmid_ar got %h/%0d exp 0000000100000040/3", bus.m_axi_araddr, bus.m_axi_arlen); else pass_cnt++;
    ar_hs();
    for (int i = 0; i < 4; i++) begin
      r_beat(32'h4400_0000 + i, 2'b00, i == 3, 0, v, d, e);
      check_cnt++; if ({v, d, e} !== {1'b1, 32'h4400_0000 + i, 1'b0}) $display("FAIL rstmid_beat%0d got v%b %h e%b exp v1 %h e0", i, v, d, e, 32'h4400_0000 + i); else pass_cnt++;
    end
    check_cnt++; if ({bus.iBus_cmd_ready, protocol_err} !== 2'b10) $display("FAIL rstmid_end got %b exp 10", {bus.iBus_cmd_ready, protocol_err}); else pass_cnt++;
  endtask

  task automatic test_missing_rlast();
    logic v, e; logic [31:0] d;
    send_cmd(32'h0000_0080, 3'd3);
    ar_hs();
    r_beat(32'h9000_0000, 2'b00, 1'b0, 0, v, d, e);
    check_cnt++; if ({bus.iBus_cmd_ready, protocol_err} !== 2'b00) $display("FAIL nolast_mid got %b exp 00", {bus.iBus_cmd_ready, protocol_err}); else pass_cnt++;
    r_beat(32'h9000_0001, 2'b00, 1'b0, 0, v, d, e);
    check_cnt++; if ({v, d, bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err} !== {1'b1, 32'h9000_0001, 3'b101})
      $display("FAIL nolast_end got v%b %h r%b rr%b pe%b exp v1 90000001 r1 rr0 pe1", v, d, bus.iBus_cmd_ready, bus.m_axi_rready, protocol_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_translated();
    test_absolute();
    test_single();
    test_stalls();
    test_early_rlast();
    test_back_to_back();
    test_boundary();
    test_reset_mid_burst();
    test_missing_rlast();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
